// File: rtl/alu_issue_seq.sv
// alu_issue_seq: accepts encoded operation words and reads their operands
// from a local 32-entry register file. It drives a combinational ALU, waits
// a fixed number of cycles, writes the result back to the register file and
// reports each completion on a valid/ready channel. This block does no
// arithmetic of its own.
module alu_issue_seq #(
    parameter int ALU_LAT = 1,   // cycles from ALU port update to result sample (1..15)
    parameter int NREG    = 32   // register-file entries (5-bit register fields)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_word,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [15:0] alu_imm,
    output logic [4:0]  alu_sh,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_in1_q, alu_in1_d;
    logic [31:0] alu_in2_q, alu_in2_d;
    logic [15:0] alu_imm_q, alu_imm_d;
    logic [4:0]  alu_sh_q, alu_sh_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Register-file write port, driven from the WAIT state.
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] regs_q [NREG];

    // Fields of the latched operation word.
    logic [4:0]  f_op, f_rd, f_rs, f_rt, f_sh;
    logic [15:0] f_imm;
    logic        f_iform;

    // Bit 0 of the operation word carries no meaning in either form.
    logic        unused_op_bit;
    assign unused_op_bit = op_q[0];

    assign f_op    = op_q[31:27];
    assign f_rd    = op_q[26:22];
    assign f_rs    = op_q[21:17];
    assign f_rt    = op_q[16:12];
    assign f_sh    = op_q[11:7];
    assign f_imm   = op_q[16:1];
    assign f_iform = op_q[31];

    // Output view of the sequencer state and of the held ALU/completion regs.
    assign op_ready = (state_q == IDLE) && !rst;
    assign wb_valid = (state_q == WB);
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign alu_in1  = alu_in1_q;
    assign alu_in2  = alu_in2_q;
    assign alu_imm  = alu_imm_q;
    assign alu_sh   = alu_sh_q;
    assign alu_op   = alu_op_q;
    assign dbg_data = regs_q[dbg_addr];

    // Register file: one flop word per entry. Entry 0 is never written, so
    // it stays at its reset value of zero and always reads 0.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            // Capture the write-back value when this entry is addressed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (rf_we && (rf_waddr == 5'(gi))) begin
                    regs_q[gi] <= rf_wdata;
                end
            end
        end
    endgenerate

    // State, latched operation, latency counter, ALU ports and completion record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
            alu_imm_q <= '0;
            alu_sh_q  <= '0;
            alu_op_q  <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            alu_in1_q <= alu_in1_d;
            alu_in2_q <= alu_in2_d;
            alu_imm_q <= alu_imm_d;
            alu_sh_q  <= alu_sh_d;
            alu_op_q  <= alu_op_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Next-state logic: everything holds by default, so the ALU ports stay
    // stable through WAIT and the completion record stays stable through WB.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        alu_in1_d = alu_in1_q;
        alu_in2_d = alu_in2_q;
        alu_imm_d = alu_imm_q;
        alu_sh_d  = alu_sh_q;
        alu_op_d  = alu_op_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        rf_we     = 1'b0;
        rf_waddr  = f_rd;
        rf_wdata  = alu_result;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d    = op_word;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                alu_op_d  = f_op;
                alu_in1_d = regs_q[f_rs];
                if (f_iform) begin
                    alu_in2_d = '0;
                    alu_imm_d = f_imm;
                    alu_sh_d  = '0;
                end else begin
                    alu_in2_d = regs_q[f_rt];
                    alu_imm_d = '0;
                    alu_sh_d  = f_sh;
                end
                cnt_d   = 4'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Writes to register 0 are dropped but still reported.
                    rf_we     = (f_rd != 5'd0);
                    wb_rd_d   = f_rd;
                    wb_data_d = alu_result;
                    state_d   = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator-side sequencer for the ALU. It drives the ALU's in1/in2/imm/sh/ALUop inputs and consumes its 32-bit result.
- Accepts encoded operation words over a valid/ready handshake and reads operands from an internal register file.
- Issues the operation to the ALU, waits a fixed latency, writes the result back to the register file, and reports each completion on a valid/ready output.
- Sits between the instruction source and the combinational ALU.

Parameters:
- ALU_LAT, 1, cycles from ALU port update to result sampling (1..15).
- NREG, 32, register-file entries; fixed at 32, since register fields are 5 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  op_word valid.
- op_ready  out  1  sequencer can accept an op_word.
- op_word  in  32  encoded operation, format below.
- alu_in1  out  32  ALU operand 1, to the ALU in1.
- alu_in2  out  32  ALU operand 2, to the ALU in2.
- alu_imm  out  16  ALU immediate, to the ALU imm.
- alu_sh  out  5  shift amount, to the ALU sh.
- alu_op  out  5  ALU opcode, to the ALU ALUop.
- alu_result  in  32  ALU result.
- wb_valid  out  1  completion record valid.
- wb_ready  in  1  consumer accepts the completion record.
- wb_rd  out  5  destination register written.
- wb_data  out  32  value written.
- dbg_addr  in  5  debug register-file read address.
- dbg_data  out  32  combinational read of reg[dbg_addr].

Behaviour:
- Reset (async, rst=1): state=IDLE; all 32 registers=0; all alu_* outputs=0; wb_valid=0, wb_rd=0, wb_data=0; op_ready=0 while rst=1.
- Reset asserted mid-operation aborts the operation: no register write, no wb_valid.
- op_word format:
  - [31:27] op; [26:22] rd; [21:17] rs.
  - R-form (op[4]=0): [16:12] rt, [11:7] sh, [6:0] ignored.
  - I-form (op[4]=1): [16:1] imm, [0] ignored.
- Register 0 always reads 0. Writes to rd=0 are discarded, but the completion is still reported with wb_data=ALU result.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_word and go to ISSUE. There is no acceptance in any other state.
- ISSUE (1 cycle): register the ALU ports:
  - alu_op=op; alu_in1=reg[rs].
  - alu_in2=reg[rt] for R-form, 0 for I-form.
  - alu_imm=imm for I-form, 0 for R-form.
  - alu_sh=sh for R-form, 0 for I-form.
  - Load the wait counter with ALU_LAT-1, then go to WAIT.
- WAIT: decrement the counter each cycle. When it is 0, sample alu_result and write reg[rd] (unless rd=0). Load wb_rd=rd and wb_data=alu_result, then go to WB.
  - With ALU_LAT=1, the ports change on one edge and the result is captured on the next edge.
- WB: wb_valid=1; wb_rd and wb_data are held stable until wb_ready=1. On wb_valid&wb_ready, go to IDLE.
  - wb_ready is ignored outside WB.
- alu_* outputs hold their last issued values after ISSUE until the next ISSUE or reset, so the ALU inputs stay stable through WAIT.
- Latency from acceptance edge to wb_valid rising: ALU_LAT+1 cycles. Throughput is one op per ALU_LAT+3 cycles when wb_ready=1.
- Back-to-back dependence (rs or rt equal to the previous rd) sees the written value, because the write completes before IDLE.
- dbg_data is combinational and reflects a write from the edge after that write's clock edge.
- No arithmetic is done in this block. Widths pass through unchanged. The imm is not sign-extended here; that is the ALU's job.

Test Plan:
The bench ALU stub computes: op 0 → in1+in2; op 16 → in1+sext(imm); op 2 → in2<<sh. All other ops return 0.
1. Reset, then dbg_addr sweep 0..31 → every dbg_data=0. op_ready=1, wb_valid=0, all alu_* outputs=0.
2. Seed: I-form op=16, rd=1, rs=0, imm=0x0005 → wb_valid with wb_rd=1, wb_data=5, exactly 2 cycles after acceptance (ALU_LAT=1). Then R-form op=0, rd=2, rs=1, rt=1 → wb_data=10; dbg_addr=2 reads 10.
3. Shift: R-form op=2, rd=3, rt=2 (reg[2]=10), sh=4 → alu_sh=4, alu_in2=10, wb_data=160. A following op_valid held high is not accepted until the WB handshake completes.
4. Backpressure: hold wb_ready=0 for 5 cycles in WB → wb_valid, wb_rd and wb_data are stable and op_ready=0. Release → return to IDLE next cycle.
5. rd=0: I-form op=16, rd=0, imm=0x0007 → completion reported with wb_rd=0, wb_data=7. reg[0] still reads 0.
6. Reset mid-WAIT (ALU_LAT=4, rst pulsed during WAIT) → no write to the target rd, wb_valid never rises, all registers=0, state=IDLE, op_ready=1 after rst deasserts.
